// File: rtl/mem_arbiter.sv
// Purpose: shares one memory bus between instruction fetch (I) and load/store (D), one transaction at a time.
// Latency: request seen in IDLE at cycle N -> b_valid at N+1 -> x_ready at N+1 at the earliest (2 cycles minimum).
// Backpressure: requesters hold x_valid until the x_ready pulse; stall_if/stall_mem freeze the pipeline meanwhile.
// Optional build macro MEM_ARB_RR_EN: round-robin on a tie in IDLE instead of fixed D-over-I priority.
module mem_arbiter #(
    parameter int ADDR_W      = 64,
    parameter int DATA_W      = 64,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                i_valid,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_ready,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_valid,
    input  logic                d_write,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_strobe,
    output logic                d_ready,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                b_valid,
    output logic                b_write,
    output logic [ADDR_W-1:0]   b_addr,
    output logic [DATA_W-1:0]   b_wdata,
    output logic [DATA_W/8-1:0] b_strobe,
    input  logic                b_ready,
    input  logic [DATA_W-1:0]   b_rdata,
    output logic                stall_if,
    output logic                stall_mem,
    output logic                timeout
);

    localparam int          STRB_W = DATA_W / 8;
    localparam logic [15:0] TO_CNT = 16'(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    state_t              state_q;
    logic [15:0]         cnt_q;
    logic                b_valid_q;
    logic                b_write_q;
    logic [ADDR_W-1:0]   b_addr_q;
    logic [DATA_W-1:0]   b_wdata_q;
    logic [STRB_W-1:0]   b_strobe_q;

    logic gnt_i;
    logic gnt_d;
    logic to_hit;
    logic finish;
    logic pick_d;

    assign gnt_i  = (state_q == GNT_I);
    assign gnt_d  = (state_q == GNT_D);
    // Abort only when the wait budget is used up and the bus still has not answered.
    assign to_hit = (gnt_i | gnt_d) & ~b_ready & (cnt_q == TO_CNT);
    assign finish = (gnt_i | gnt_d) & (b_ready | to_hit);

`ifdef MEM_ARB_RR_EN
    // 1 = D owned the most recent completed/aborted transaction.
    logic last_owner_q;

    // On a tie, favour whichever port did not own the bus last; a lone requester always wins.
    assign pick_d = d_valid & (~i_valid | ~last_owner_q);

    // Track the owner of every completion or timeout.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_owner_q <= 1'b0;
        end else if (finish) begin
            last_owner_q <= gnt_d;
        end
    end
`else
    // Fixed priority: a load/store must never starve behind back-to-back fetches.
    assign pick_d = d_valid;
`endif

    // Arbitration FSM: latch the winner onto the bus, hold it stable, return to IDLE on completion or abort.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            b_valid_q  <= 1'b0;
            b_write_q  <= 1'b0;
            b_addr_q   <= '0;
            b_wdata_q  <= '0;
            b_strobe_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (pick_d) begin
                        state_q    <= GNT_D;
                        b_valid_q  <= 1'b1;
                        b_write_q  <= d_write;
                        b_addr_q   <= d_addr;
                        b_wdata_q  <= d_wdata;
                        b_strobe_q <= d_strobe;
                    end else if (i_valid) begin
                        state_q    <= GNT_I;
                        b_valid_q  <= 1'b1;
                        b_write_q  <= 1'b0;
                        b_addr_q   <= i_addr;
                        b_wdata_q  <= '0;
                        b_strobe_q <= '0;
                    end else begin
                        b_valid_q  <= 1'b0;
                    end
                end
                GNT_I, GNT_D: begin
                    // Every transaction passes through IDLE, so there is never a same-cycle re-grant.
                    if (finish) begin
                        state_q   <= IDLE;
                        b_valid_q <= 1'b0;
                        cnt_q     <= '0;
                    end else begin
                        cnt_q     <= cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    b_valid_q <= 1'b0;
                    cnt_q     <= '0;
                end
            endcase
        end
    end

    assign b_valid  = b_valid_q;
    assign b_write  = b_write_q;
    assign b_addr   = b_addr_q;
    assign b_wdata  = b_wdata_q;
    assign b_strobe = b_strobe_q;

    // Completion is combinational so the owner sees it in the same cycle as b_ready.
    assign i_ready   = gnt_i & (b_ready | to_hit);
    assign d_ready   = gnt_d & (b_ready | to_hit);
    // Aborted transactions and stores return zero data.
    assign i_rdata   = (gnt_i & b_ready) ? b_rdata : '0;
    assign d_rdata   = (gnt_d & b_ready & ~b_write_q) ? b_rdata : '0;
    assign timeout   = to_hit;

    assign stall_if  = i_valid & ~i_ready;
    assign stall_mem = d_valid & ~d_ready;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed checks of mem_arbiter: reset, fetch, store with waits, conflict, timeout, mid-transaction reset, starvation.
// Inputs change 1 time unit after each rising edge; outputs are sampled 1 unit later, well away from the edge.
// Default (fixed-priority) build with TIMEOUT_CYC=4.
module tb_mem_arbiter;

    logic        clk;
    logic        resetn;
    logic        i_valid;
    logic [63:0] i_addr;
    logic        i_ready;
    logic [63:0] i_rdata;
    logic        d_valid;
    logic        d_write;
    logic [63:0] d_addr;
    logic [63:0] d_wdata;
    logic [7:0]  d_strobe;
    logic        d_ready;
    logic [63:0] d_rdata;
    logic        b_valid;
    logic        b_write;
    logic [63:0] b_addr;
    logic [63:0] b_wdata;
    logic [7:0]  b_strobe;
    logic        b_ready;
    logic [63:0] b_rdata;
    logic        stall_if;
    logic        stall_mem;
    logic        timeout;

    int n_pass  = 0;
    int n_total = 0;

    mem_arbiter #(
        .ADDR_W      (64),
        .DATA_W      (64),
        .TIMEOUT_CYC (4)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .i_valid   (i_valid),
        .i_addr    (i_addr),
        .i_ready   (i_ready),
        .i_rdata   (i_rdata),
        .d_valid   (d_valid),
        .d_write   (d_write),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_strobe  (d_strobe),
        .d_ready   (d_ready),
        .d_rdata   (d_rdata),
        .b_valid   (b_valid),
        .b_write   (b_write),
        .b_addr    (b_addr),
        .b_wdata   (b_wdata),
        .b_strobe  (b_strobe),
        .b_ready   (b_ready),
        .b_rdata   (b_rdata),
        .stall_if  (stall_if),
        .stall_mem (stall_mem),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after new inputs.
    task automatic settle();
        #1;
    endtask

    initial begin
        resetn   = 1'b0;
        i_valid  = 1'b0;
        i_addr   = '0;
        d_valid  = 1'b0;
        d_write  = 1'b0;
        d_addr   = '0;
        d_wdata  = '0;
        d_strobe = '0;
        b_ready  = 1'b0;
        b_rdata  = '0;

        // ---------------- reset state ----------------
        #2;
        chk("rst_b_valid", 64'(b_valid), 64'd0);
        chk("rst_i_ready", 64'(i_ready), 64'd0);
        chk("rst_d_ready", 64'(d_ready), 64'd0);
        chk("rst_timeout", 64'(timeout), 64'd0);
        chk("rst_i_rdata", i_rdata, 64'd0);
        chk("rst_d_rdata", d_rdata, 64'd0);
        chk("rst_b_addr",  b_addr, 64'd0);
        cyc();
        cyc();
        resetn = 1'b1;

        // ---------------- single fetch ----------------
        cyc();
        i_valid = 1'b1;
        i_addr  = 64'h8000_0000;
        settle();
        chk("f_c1_stall_if", 64'(stall_if), 64'd1);
        chk("f_c1_b_valid",  64'(b_valid),  64'd0);
        chk("f_c1_i_ready",  64'(i_ready),  64'd0);
        cyc();
        b_ready = 1'b1;
        b_rdata = 64'h13;
        settle();
        chk("f_c2_b_valid",  64'(b_valid),  64'd1);
        chk("f_c2_b_addr",   b_addr,        64'h8000_0000);
        chk("f_c2_b_write",  64'(b_write),  64'd0);
        chk("f_c2_i_ready",  64'(i_ready),  64'd1);
        chk("f_c2_i_rdata",  i_rdata,       64'h13);
        chk("f_c2_d_ready",  64'(d_ready),  64'd0);
        chk("f_c2_stall_if", 64'(stall_if), 64'd0);
        cyc();
        i_valid = 1'b0;
        b_ready = 1'b0;
        settle();
        chk("f_c3_b_valid",  64'(b_valid),  64'd0);
        chk("f_c3_i_ready",  64'(i_ready),  64'd0);

        // ---------------- store with 3 wait cycles ----------------
        cyc();
        d_valid  = 1'b1;
        d_write  = 1'b1;
        d_addr   = 64'h100;
        d_wdata  = 64'hDEAD_BEEF;
        d_strobe = 8'h0F;
        settle();
        chk("s_idle_stall_mem", 64'(stall_mem), 64'd1);
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("s_wait_b_valid",   64'(b_valid),   64'd1);
            chk("s_wait_b_write",   64'(b_write),   64'd1);
            chk("s_wait_b_addr",    b_addr,         64'h100);
            chk("s_wait_b_wdata",   b_wdata,        64'hDEAD_BEEF);
            chk("s_wait_b_strobe",  64'(b_strobe),  64'h0F);
            chk("s_wait_d_ready",   64'(d_ready),   64'd0);
            chk("s_wait_stall_mem", 64'(stall_mem), 64'd1);
        end
        cyc();
        b_ready = 1'b1;
        b_rdata = 64'h5555_AAAA;
        settle();
        chk("s_done_b_wdata",   b_wdata,        64'hDEAD_BEEF);
        chk("s_done_b_strobe",  64'(b_strobe),  64'h0F);
        chk("s_done_d_ready",   64'(d_ready),   64'd1);
        chk("s_done_d_rdata",   d_rdata,        64'd0);
        chk("s_done_i_ready",   64'(i_ready),   64'd0);
        chk("s_done_stall_mem", 64'(stall_mem), 64'd0);
        cyc();
        d_valid = 1'b0;
        d_write = 1'b0;
        b_ready = 1'b0;
        settle();
        chk("s_after_b_valid", 64'(b_valid), 64'd0);
        chk("s_after_d_ready", 64'(d_ready), 64'd0);

        // ---------------- conflict: D then I ----------------
        cyc();
        i_valid = 1'b1;
        i_addr  = 64'h4000;
        d_valid = 1'b1;
        d_write = 1'b0;
        d_addr  = 64'h200;
        settle();
        chk("c_idle_stall_if",  64'(stall_if),  64'd1);
        chk("c_idle_stall_mem", 64'(stall_mem), 64'd1);
        cyc();
        b_ready = 1'b1;
        b_rdata = 64'hAA;
        settle();
        chk("c_d_b_addr",   b_addr,        64'h200);
        chk("c_d_d_ready",  64'(d_ready),  64'd1);
        chk("c_d_d_rdata",  d_rdata,       64'hAA);
        chk("c_d_i_ready",  64'(i_ready),  64'd0);
        chk("c_d_stall_if", 64'(stall_if), 64'd1);
        cyc();
        d_valid = 1'b0;
        b_ready = 1'b0;
        settle();
        chk("c_gap_b_valid",  64'(b_valid),  64'd0);
        chk("c_gap_stall_if", 64'(stall_if), 64'd1);
        cyc();
        b_ready = 1'b1;
        b_rdata = 64'hBB;
        settle();
        chk("c_i_b_addr",  b_addr,       64'h4000);
        chk("c_i_i_ready", 64'(i_ready), 64'd1);
        chk("c_i_i_rdata", i_rdata,      64'hBB);
        chk("c_i_d_ready", 64'(d_ready), 64'd0);
        cyc();
        i_valid = 1'b0;
        b_ready = 1'b0;
        settle();
        chk("c_end_b_valid", 64'(b_valid), 64'd0);

        // ---------------- timeout ----------------
        cyc();
        i_valid = 1'b1;
        i_addr  = 64'h1000;
        b_rdata = 64'hFF;
        settle();
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("t_wait_b_valid", 64'(b_valid), 64'd1);
            chk("t_wait_timeout", 64'(timeout), 64'd0);
            chk("t_wait_i_ready", 64'(i_ready), 64'd0);
        end
        cyc();
        chk("t_hit_timeout", 64'(timeout), 64'd1);
        chk("t_hit_i_ready", 64'(i_ready), 64'd1);
        chk("t_hit_i_rdata", i_rdata,      64'd0);
        chk("t_hit_d_ready", 64'(d_ready), 64'd0);
        cyc();
        i_valid = 1'b0;
        b_ready = 1'b1;
        settle();
        chk("t_late_b_valid", 64'(b_valid), 64'd0);
        chk("t_late_i_ready", 64'(i_ready), 64'd0);
        chk("t_late_timeout", 64'(timeout), 64'd0);
        cyc();
        b_ready = 1'b0;
        settle();
        chk("t_idle_b_valid", 64'(b_valid), 64'd0);

        // ---------------- reset mid-transaction ----------------
        cyc();
        d_valid = 1'b1;
        d_write = 1'b0;
        d_addr  = 64'h300;
        settle();
        cyc();
        chk("r_gnt_b_valid", 64'(b_valid), 64'd1);
        resetn  = 1'b0;
        b_ready = 1'b1;
        settle();
        chk("r_rst_b_valid",   64'(b_valid),   64'd0);
        chk("r_rst_d_ready",   64'(d_ready),   64'd0);
        chk("r_rst_stall_mem", 64'(stall_mem), 64'd1);
        cyc();
        resetn  = 1'b1;
        b_ready = 1'b0;
        settle();
        chk("r_idle_b_valid", 64'(b_valid), 64'd0);
        cyc();
        b_ready = 1'b1;
        b_rdata = 64'h77;
        settle();
        chk("r_regnt_b_valid", 64'(b_valid), 64'd1);
        chk("r_regnt_b_addr",  b_addr,       64'h300);
        chk("r_regnt_d_ready", 64'(d_ready), 64'd1);
        chk("r_regnt_d_rdata", d_rdata,      64'h77);
        cyc();
        d_valid = 1'b0;
        b_ready = 1'b0;
        settle();

        // ---------------- continuous D starves I ----------------
        cyc();
        i_valid = 1'b1;
        i_addr  = 64'h2000;
        d_valid = 1'b1;
        d_write = 1'b0;
        d_addr  = 64'h400;
        b_ready = 1'b1;
        b_rdata = 64'h99;
        settle();
        chk("p_c0_i_ready", 64'(i_ready), 64'd0);
        for (int k = 1; k < 6; k++) begin
            cyc();
            chk("p_i_ready",  64'(i_ready),  64'd0);
            chk("p_stall_if", 64'(stall_if), 64'd1);
            chk("p_d_ready",  64'(d_ready),  64'(k % 2));
        end
        cyc();
        d_valid = 1'b0;
        settle();
        chk("p_drop_b_valid", 64'(b_valid), 64'd0);
        chk("p_drop_i_ready", 64'(i_ready), 64'd0);
        cyc();
        chk("p_gnt_b_addr",  b_addr,       64'h2000);
        chk("p_gnt_i_ready", 64'(i_ready), 64'd1);
        chk("p_gnt_i_rdata", i_rdata,      64'h99);
        cyc();
        i_valid = 1'b0;
        b_ready = 1'b0;
        settle();
        chk("p_end_b_valid", 64'(b_valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
